// File: rtl/rle_pixel_sequencer.sv
// rle_pixel_sequencer: expands RLE (length, colour) runs into per-pixel colour over active video, frame-aligned on vsync.
module rle_pixel_sequencer #(
    parameter int COLOUR_BITS = 6,
    parameter int RUN_BITS    = 10,
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   blank,
    input  logic                   vsync_pulse,
    input  logic                   run_valid,
    input  logic [RUN_BITS-1:0]    run_length,
    input  logic [COLOUR_BITS-1:0] run_colour,
    output logic                   run_ready,
    output logic                   frame_start,
    output logic [COLOUR_BITS-1:0] colour,
    output logic                   underflow,
    output logic                   frame_err
);
    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int CNT_BITS = $clog2(TOTAL + 1);
    localparam logic [CNT_BITS-1:0] TOTAL_C = CNT_BITS'(TOTAL);
    localparam logic [CNT_BITS-1:0] CNT_ONE = 1;
    localparam logic [RUN_BITS:0] ONE = 1;
    localparam logic [0:0] WAIT_FRAME = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [RUN_BITS:0]      remaining_q, remaining_d;
    logic [COLOUR_BITS-1:0] cur_colour_q, cur_colour_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic [COLOUR_BITS-1:0] colour_q, colour_d;
    logic                   frame_start_q, frame_start_d;
    logic                   underflow_q, underflow_d;
    logic                   frame_err_q, frame_err_d;
    logic                   active, consume, has_run, handshake, frame_end;

    assign active    = state_q == ACTIVE;
    assign consume   = active && !blank;
    assign has_run   = remaining_q != '0;
    assign frame_end = active && vsync_pulse;
    assign run_ready = active && !vsync_pulse && (!has_run || (remaining_q == ONE && !blank));
    assign handshake = run_valid && run_ready;

    always_comb begin
        state_d       = (state_q == WAIT_FRAME && vsync_pulse) ? ACTIVE : state_q;
        frame_start_d = vsync_pulse;
        colour_d      = (consume && has_run) ? cur_colour_q : '0;
        underflow_d   = underflow_q | (consume && !has_run);
        frame_err_d   = frame_err_q | (frame_end && (cnt_q != TOTAL_C || has_run));
        // a token loaded on the last pixel of the current run replaces the decrement, keeping pixels gapless
        remaining_d   = frame_end ? '0 :
                        handshake ? {1'b0, run_length} + ONE :
                        (consume && has_run) ? remaining_q - ONE : remaining_q;
        cur_colour_d  = frame_end ? '0 : handshake ? run_colour : cur_colour_q;
        cnt_d         = frame_end ? '0 : (consume && cnt_q != TOTAL_C) ? cnt_q + CNT_ONE : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_FRAME;
            remaining_q   <= '0;
            cur_colour_q  <= '0;
            cnt_q         <= '0;
            colour_q      <= '0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            cur_colour_q  <= cur_colour_d;
            cnt_q         <= cnt_d;
            colour_q      <= colour_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign colour      = colour_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;
    assign frame_err   = frame_err_q;
endmodule
